maxpool_stream: RTL and testbench

//  Streaming multi-channel max-pool for the Accelerator datapath. Consumes one

---
 rtl/maxpool_stream.sv | 185 ++++++++++++++++++
 tb/tb_maxpool_stream.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream.sv
// Streaming KxK max-pool (stride K) over a raster pixel stream with CH parallel channels.
// Partial window maxima are kept in a single row buffer indexed by output column.
module maxpool_stream #(
  parameter int IN_W   = 8,
  parameter int IN_H   = 8,
  parameter int K      = 2,
  parameter int CH     = 4,
  parameter int BW     = 8,
  parameter int SIGNED = 0,
  localparam int OUT_W = IN_W / K,
  localparam int OUT_H = IN_H / K,
  localparam int ORW   = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int OCW   = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic               clk_en,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH*BW-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH*BW-1:0]   out_data,
  output logic [ORW-1:0]     out_row,
  output logic [OCW-1:0]     out_col,
  output logic               frame_done
);

  localparam int CW = $clog2(IN_W + 1);
  localparam int RW = $clog2(IN_H + 1);
  localparam int KW = $clog2(K + 1);
  localparam int DW = CH * BW;

  logic [CW-1:0]  col_q, col_d, oc_q, oc_d;
  logic [RW-1:0]  row_q, row_d, orow_q, orow_d;
  logic [KW-1:0]  kc_q, kc_d, kr_q, kr_d;
  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  out_data_q, out_data_d;
  logic [ORW-1:0] out_row_q, out_row_d;
  logic [OCW-1:0] out_col_q, out_col_d;
  logic           frame_done_q, frame_done_d;
  logic [DW-1:0]  buf_q [OUT_W];
  logic [DW-1:0]  buf_d [OUT_W];

  logic           accept, out_fire, discard, first, last, col_end, row_end;
  logic [OCW-1:0] buf_idx;
  logic [DW-1:0]  stored, merged;

  function automatic logic greater(input logic [BW-1:0] a, input logic [BW-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  assign in_ready   = reset_n && !clear && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign out_fire   = out_valid_q && out_ready;
  // Columns/rows past the last full window map to oc/orow beyond the output grid.
  assign discard    = (oc_q >= CW'(OUT_W)) || (orow_q >= RW'(OUT_H));
  assign first      = (kr_q == '0) && (kc_q == '0);
  assign last       = (kr_q == KW'(K - 1)) && (kc_q == KW'(K - 1));
  assign col_end    = (col_q == CW'(IN_W - 1));
  assign row_end    = (row_q == RW'(IN_H - 1));
  assign buf_idx    = oc_q[OCW-1:0];

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;

  always_comb begin
    stored = buf_q[buf_idx];
    merged = stored;
    if (first) begin
      merged = in_data;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (greater(in_data[c*BW +: BW], stored[c*BW +: BW]))
          merged[c*BW +: BW] = in_data[c*BW +: BW];
      end
    end
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    oc_d         = oc_q;
    orow_d       = orow_q;
    kc_d         = kc_q;
    kr_d         = kr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    buf_d        = buf_q;
    frame_done_d = out_fire && (out_row_q == ORW'(OUT_H - 1)) && (out_col_q == OCW'(OUT_W - 1));

    if (out_fire) out_valid_d = 1'b0;

    if (accept) begin
      if (col_end) begin
        col_d = '0;
        kc_d  = '0;
        oc_d  = '0;
        if (row_end) begin
          row_d  = '0;
          kr_d   = '0;
          orow_d = '0;
        end else begin
          row_d = row_q + 1'b1;
          if (kr_q == KW'(K - 1)) begin
            kr_d   = '0;
            orow_d = orow_q + 1'b1;
          end else begin
            kr_d = kr_q + 1'b1;
          end
        end
      end else begin
        col_d = col_q + 1'b1;
        if (kc_q == KW'(K - 1)) begin
          kc_d = '0;
          oc_d = oc_q + 1'b1;
        end else begin
          kc_d = kc_q + 1'b1;
        end
      end

      if (!discard) begin
        buf_d[buf_idx] = merged;
        if (last) begin
          out_valid_d = 1'b1;
          out_data_d  = merged;
          out_row_d   = orow_q[ORW-1:0];
          out_col_d   = buf_idx;
        end
      end
    end

    // Abort drops any held result; accept is already blocked via in_ready.
    if (clear) begin
      col_d        = '0;
      row_d        = '0;
      oc_d         = '0;
      orow_d       = '0;
      kc_d         = '0;
      kr_d         = '0;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk_en or negedge reset_n) begin
    if (!reset_n) begin
      col_q        <= '0;
      row_q        <= '0;
      oc_q         <= '0;
      orow_q       <= '0;
      kc_q         <= '0;
      kr_q         <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      oc_q         <= oc_d;
      orow_q       <= orow_d;
      kc_q         <= kc_d;
      kr_q         <= kr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  // The row buffer needs no reset: the first pixel of every window overwrites it.
  always_ff @(posedge clk_en) begin
    for (int i = 0; i < OUT_W; i++) buf_q[i] <= buf_d[i];
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Scoreboard bench: an unsigned and a signed 5x5/K=2/CH=4 instance share one input stream;
// expected pooled pixels are computed from the whole frame image and queued as it is driven.
module tb_maxpool_stream;

  localparam int IN_W = 5;
  localparam int IN_H = 5;
  localparam int K    = 2;
  localparam int CH   = 4;
  localparam int BW   = 8;
  localparam int NPIX = IN_W * IN_H;
  localparam int DW   = CH * BW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, clear, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready_u, out_valid_u, frame_done_u;
  logic [DW-1:0] out_data_u;
  logic [0:0]    out_row_u, out_col_u;
  logic          in_ready_s, out_valid_s, frame_done_s;
  logic [DW-1:0] out_data_s;
  logic [0:0]    out_row_s, out_col_s;

  maxpool_stream #(.IN_W(IN_W), .IN_H(IN_H), .K(K), .CH(CH), .BW(BW), .SIGNED(0)) dutU (
    .clk_en(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
    .out_row(out_row_u), .out_col(out_col_u), .frame_done(frame_done_u)
  );

  maxpool_stream #(.IN_W(IN_W), .IN_H(IN_H), .K(K), .CH(CH), .BW(BW), .SIGNED(1)) dutS (
    .clk_en(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_row(out_row_s), .out_col(out_col_s), .frame_done(frame_done_s)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  r;
    logic [7:0]  c;
  } exp_t;

  exp_t        qU[$];
  exp_t        qS[$];
  int          checks = 0;
  int          errors = 0;
  int          fdU = 0;
  int          fdS = 0;
  int          bpMode = 0;
  int          stallCnt = 0;
  logic [31:0] img [NPIX];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pick(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    if (sgn) return ($signed(a) > $signed(b)) ? a : b;
    else     return (a > b) ? a : b;
  endfunction

  // Expected outputs come straight from the full frame image, window by window.
  task automatic pushExpected();
    for (int orow = 0; orow < IN_H / K; orow++) begin
      for (int ocol = 0; ocol < IN_W / K; ocol++) begin
        exp_t eu, es;
        eu.r = 8'(orow); eu.c = 8'(ocol); eu.d = '0;
        es = eu;
        for (int ch = 0; ch < CH; ch++) begin
          logic [7:0] mu, ms, v;
          mu = img[(orow*K)*IN_W + ocol*K][ch*BW +: BW];
          ms = mu;
          for (int dr = 0; dr < K; dr++) begin
            for (int dc = 0; dc < K; dc++) begin
              v  = img[(orow*K + dr)*IN_W + ocol*K + dc][ch*BW +: BW];
              mu = pick(mu, v, 1'b0);
              ms = pick(ms, v, 1'b1);
            end
          end
          eu.d[ch*BW +: BW] = mu;
          es.d[ch*BW +: BW] = ms;
        end
        qU.push_back(eu);
        qS.push_back(es);
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pix);
    in_valid = 1'b1;
    in_data  = pix;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready_u) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    checkOutput("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic sendBeats(input int n);
    for (int i = 0; i < n; i++) applyStimulus(img[i]);
  endtask

  task automatic drain();
    bpMode = 0;
    for (int n = 0; n < 200; n++) begin
      if (qU.size() == 0 && qS.size() == 0) break;
      @(posedge clk);
    end
    checkOutput("drain_u", qU.size(), 0);
    checkOutput("drain_s", qS.size(), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic patternImage();
    for (int i = 0; i < NPIX; i++) begin
      for (int ch = 0; ch < CH; ch++) begin
        if (i / IN_W == 4 || i % IN_W == 4) img[i][ch*BW +: BW] = 8'hFF;
        else                                img[i][ch*BW +: BW] = 8'(ch*16 + i);
      end
    end
  endtask

  task automatic randomImage();
    for (int i = 0; i < NPIX; i++) img[i] = $urandom;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bpMode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (bpMode == 2 && out_valid_u) begin
        checkOutput("stall_in_ready", 32'(in_ready_u), 32'd0);
        if (qU.size() > 0) checkOutput("stall_data_hold", out_data_u, qU[0].d);
        stallCnt++;
        if (stallCnt >= 6) bpMode = 0;
      end
      if (out_valid_u && out_ready) begin
        if (qU.size() == 0) checkOutput("u_unexpected_out", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = qU.pop_front();
          checkOutput("u_data", out_data_u, e.d);
          checkOutput("u_row", 32'(out_row_u), 32'(e.r));
          checkOutput("u_col", 32'(out_col_u), 32'(e.c));
        end
      end
      if (out_valid_s && out_ready) begin
        if (qS.size() == 0) checkOutput("s_unexpected_out", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = qS.pop_front();
          checkOutput("s_data", out_data_s, e.d);
          checkOutput("s_row", 32'(out_row_s), 32'(e.r));
          checkOutput("s_col", 32'(out_col_s), 32'(e.c));
        end
      end
      if (frame_done_u) fdU++;
      if (frame_done_s) fdS++;
    end
  end

  initial begin
    reset_n  = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready_u), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid_u), 32'd0);
    checkOutput("rst_out_data", out_data_u, 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done_u), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 32'(in_ready_u), 32'd1);
    @(posedge clk);
    #1;

    // Frames 1 and 2: channel pattern with discarded row/col 4 full of 0xFF, back to back.
    patternImage();
    pushExpected(); sendBeats(NPIX);
    pushExpected(); sendBeats(NPIX);

    // Frame 3: signed vs unsigned compare windows.
    randomImage();
    img[0][7:0]  = 8'hFD; img[1][7:0]  = 8'hFF; img[5][7:0]  = 8'h80; img[6][7:0]  = 8'hF9;
    img[0][15:8] = 8'h7F; img[1][15:8] = 8'h80; img[5][15:8] = 8'h00; img[6][15:8] = 8'h01;
    pushExpected(); sendBeats(NPIX);
    drain();

    // Frame 4: six-cycle stall at the first result.
    patternImage();
    stallCnt = 0;
    bpMode   = 2;
    pushExpected(); sendBeats(NPIX);
    drain();

    // Frame 5: random backpressure.
    randomImage();
    bpMode = 1;
    pushExpected(); sendBeats(NPIX);
    drain();

    // Clear with a held result and a half-finished row.
    randomImage();
    bpMode = 3;
    @(posedge clk);
    #1;
    pushExpected(); sendBeats(7);
    checkOutput("held_before_clear", 32'(out_valid_u), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    checkOutput("clear_in_ready", 32'(in_ready_u), 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    checkOutput("clear_out_valid_u", 32'(out_valid_u), 32'd0);
    checkOutput("clear_out_valid_s", 32'(out_valid_s), 32'd0);
    qU.delete();
    qS.delete();
    bpMode = 0;
    @(posedge clk);
    #1;
    randomImage();
    pushExpected(); sendBeats(NPIX);
    drain();

    // Async reset mid-window with a held result.
    patternImage();
    bpMode = 3;
    @(posedge clk);
    #1;
    pushExpected(); sendBeats(7);
    checkOutput("held_before_reset", 32'(out_valid_u), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 32'(out_valid_u), 32'd0);
    checkOutput("mid_rst_out_data", out_data_u, 32'd0);
    checkOutput("mid_rst_out_row", 32'(out_row_u), 32'd0);
    checkOutput("mid_rst_out_col", 32'(out_col_u), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready_u), 32'd0);
    qU.delete();
    qS.delete();
    bpMode = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_release_ready", 32'(in_ready_u), 32'd1);
    @(posedge clk);
    #1;
    randomImage();
    pushExpected(); sendBeats(NPIX);
    drain();

    checkOutput("frame_done_count_u", fdU, 7);
    checkOutput("frame_done_count_s", fdS, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
